// File: rtl/l2_cacheline_adapter.sv
// Memory-side responder for the L2 pmem port: turns one cache-line fill or
// write-back into a fixed-length burst of s_line/s_beat little-endian beats.
module l2_cacheline_adapter #(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_line   = 256,
   parameter int unsigned s_beat   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       line_address,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [s_line-1:0] line_wdata,
   output logic [s_line-1:0] line_rdata,
   output logic              line_resp,
   output logic [31:0]       burst_address,
   output logic              burst_read,
   output logic              burst_write,
   output logic [s_beat-1:0] burst_wdata,
   input  logic [s_beat-1:0] burst_rdata,
   input  logic              burst_resp
);

   localparam int unsigned beats = s_line / s_beat;
   localparam int unsigned cnt_w = (beats > 1) ? $clog2(beats) : 1;
   localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_e;

   state_e            state_q;
   logic [cnt_w-1:0]  count_q;
   logic [31:0]       addr_q;
   logic [s_line-1:0] wdata_q;
   logic [s_line-1:0] rdata_q;
   logic              line_resp_q;
   logic              burst_read_q;
   logic              burst_write_q;
   logic [s_beat-1:0] burst_wdata_d;

   // NOTE: wide data registers are reset too, because the reset state of
   // burst_address, burst_wdata and line_rdata is externally visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         line_resp_q   <= 1'b0;
         burst_read_q  <= 1'b0;
         burst_write_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // pre-edge values of state_q and count_q.
         case (state_q)
            IDLE: begin
               // Write wins a tie; a still-held read is picked up in a later IDLE.
               if (line_write) begin
                  state_q       <= WRITE;
                  burst_write_q <= 1'b1;
                  addr_q        <= line_address & ~off_mask;
                  wdata_q       <= line_wdata;
                  count_q       <= '0;
               end else if (line_read) begin
                  state_q      <= READ;
                  burst_read_q <= 1'b1;
                  addr_q       <= line_address & ~off_mask;
                  count_q      <= '0;
               end
            end
            READ: begin
               if (burst_resp) begin
                  for (int b = 0; b < beats; b++) begin
                     if (count_q == cnt_w'(b)) rdata_q[b*s_beat +: s_beat] <= burst_rdata;
                  end
                  count_q <= count_q + 1'b1;
                  if (count_q == last_beat) begin
                     state_q      <= DONE;
                     count_q      <= '0;
                     burst_read_q <= 1'b0;
                     line_resp_q  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (burst_resp) begin
                  count_q <= count_q + 1'b1;
                  if (count_q == last_beat) begin
                     state_q       <= DONE;
                     count_q       <= '0;
                     burst_write_q <= 1'b0;
                     line_resp_q   <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q     <= IDLE;
               line_resp_q <= 1'b0;
            end
            default: begin
               state_q       <= IDLE;
               count_q       <= '0;
               line_resp_q   <= 1'b0;
               burst_read_q  <= 1'b0;
               burst_write_q <= 1'b0;
            end
         endcase
      end
   end

   // Write beat follows the counter, so it holds naturally through wait states.
   always_comb begin
      burst_wdata_d = '0;
      for (int b = 0; b < beats; b++) begin
         if (count_q == cnt_w'(b)) burst_wdata_d = wdata_q[b*s_beat +: s_beat];
      end
   end

   assign line_rdata    = rdata_q;
   assign line_resp     = line_resp_q;
   assign burst_address = addr_q;
   assign burst_read    = burst_read_q;
   assign burst_write   = burst_write_q;
   assign burst_wdata   = burst_wdata_d;

endmodule

// File: doc/l2_cacheline_adapter.md
L2_CACHELINE_ADAPTER -- requirements
Module: l2_cacheline_adapter

Interface
REQ-001 Parameters SHALL be:
- s_offset, default 5, line offset bits.
- s_line, default 256, line width in bits.
- s_beat, default 64, burst beat width in bits.
- The beat count SHALL be s_line/s_beat (4 by default).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- line_address  in  32  line request address from the L2 cache.
- line_read  in  1  line fill request.
- line_write  in  1  line write-back request.
- line_wdata  in  s_line  write-back line.
- line_rdata  out  s_line  assembled fill line.
- line_resp  out  1  one-cycle completion pulse to the L2 cache.
- burst_address  out  32  line-aligned burst address to memory.
- burst_read  out  1  burst read request.
- burst_write  out  1  burst write request.
- burst_wdata  out  s_beat  current write beat.
- burst_rdata  in  s_beat  current read beat.
- burst_resp  in  1  memory accepted or delivered one beat this cycle.

Function
REQ-003 The block SHALL be the memory-side responder for the L2 pmem interface and SHALL convert one line request into one s_line/s_beat-beat burst.
REQ-004 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-005 Requests SHALL be sampled only in IDLE.
- line_write=1 -> WRITE.
- Else line_read=1 -> READ.
- Both high -> WRITE, and the read is serviced in a later IDLE cycle if it is still held.
REQ-006 On leaving IDLE, the block SHALL latch burst_address = {line_address[31:s_offset], s_offset zeros}, and on a write it SHALL also latch line_wdata.
REQ-007 After acceptance, line_address and line_wdata changes SHALL have no effect until the next IDLE.
REQ-008 burst_read SHALL be 1 exactly while in READ, and burst_write SHALL be 1 exactly while in WRITE.
REQ-009 A 2-bit beat counter SHALL clear on leaving IDLE and SHALL increment on each burst_resp=1 cycle in READ or WRITE.
REQ-010 Beats SHALL be little-endian: beat n maps to line bits [64n+63:64n].
REQ-011 READ: on each burst_resp=1 cycle, burst_rdata SHALL be captured into line_rdata beat slot count.
REQ-012 WRITE: burst_wdata SHALL equal latched beat slot count, and SHALL hold until burst_resp=1.
REQ-013 burst_resp=0 cycles (wait states) SHALL be allowed between beats, and during them the state, count and outputs SHALL hold.
REQ-014 On the burst_resp=1 edge with count=3, the FSM SHALL go to DONE, and the counter SHALL wrap to 0.
REQ-015 DONE SHALL:
- assert line_resp=1 for exactly one cycle, with line_rdata valid that cycle after a read;
- then go to IDLE unconditionally.
REQ-016 The L2 cache SHALL deassert its request in the line_resp cycle; a request still high in the following IDLE cycle SHALL start a new transaction.
REQ-017 Latency: with burst_resp=1 every cycle, line_resp SHALL assert 5 cycles after the request is first sampled in IDLE (1 accept + 4 beats); each wait state SHALL add 1 cycle.
REQ-018 burst_resp while in IDLE or DONE SHALL be ignored.
REQ-019 line_rdata SHALL hold its last assembled line until overwritten by the next READ beats; a write transaction SHALL NOT modify it.

Reset
REQ-020 reset=0 SHALL asynchronously force:
- state to IDLE and count to 0;
- line_resp, burst_read and burst_write to 0;
- burst_address, burst_wdata and line_rdata to 0.
REQ-021 Reset asserted mid-burst SHALL abandon the transaction without a line_resp pulse, and SHALL NOT leave any partial-burst request asserted.
REQ-022 After reset deasserts, the first rising edge SHALL sample requests as in IDLE.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- Read, no waits: line_read=1, line_address=0x0000_1234, beats 0x11..11/0x22..22/0x33..33/0x44..44 -> burst_address=0x0000_1220; line_resp at cycle 5; line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with waits: line_write=1, line_wdata = {D3,D2,D1,D0}, burst_resp low 2 cycles before each beat -> burst_wdata = D0,D1,D2,D3, each held through its wait; line_resp at cycle 13.
- Simultaneous request: line_read=1 and line_write=1 in IDLE -> WRITE burst first; then, with line_read still held after line_resp, a READ burst follows.
- Reset mid-burst: reset=0 after beat 2 of a read -> burst_read=0 immediately; no line_resp pulse; count=0; next read completes normally.
- Spurious response: burst_resp=1 in IDLE and DONE -> no state change; no line_rdata change.
- Address change after accept: line_address changed during READ -> burst_address unchanged.
